// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU/load/store commands and issues them one at a time to the ALU/memory stage; ALU/load response 6 cycles after accept, stalls in RESP while rsp_ready=0.
// Optional STORE_ACK_EN: stores return a zero-data response instead of retiring silently.

module alu_cmd_sequencer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_b,
  input  logic [3:0] cmd_addr,
  output logic       alu_start,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [2:0] alu_op,
  output logic [3:0] alu_addr,
  input  logic       alu_done,
  input  logic [2:0] alu_y,
  input  logic [2:0] alu_memout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE_WAIT, RESP} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] addr;
  } cmd_t;

  state_t     state, state_nxt;
  cmd_t       cmd_in, head;
  logic       fifo_full, fifo_empty, push, pop;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       rsp_load;
  logic [2:0] rsp_data_nxt;
  logic       rsp_err_nxt;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, addr: cmd_addr};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  alu_cmd_sequencer_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (cmd_in),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Counter value in WAIT is the number of WAIT cycles already completed.
  assign tmo_hit   = (({1'b0, tmo_cnt} + 9'd1) == 9'(TIMEOUT));
  assign alu_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    rsp_load     = 1'b0;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = (alu_op[2:1] == 2'b11) ? STORE_WAIT : WAIT;
      WAIT: begin
        if (alu_done) begin
          rsp_load     = 1'b1;
          rsp_data_nxt = alu_op[2] ? alu_memout : alu_y;
          state_nxt    = RESP;
        end else if (tmo_hit) begin
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = RESP;
        end
      end
      STORE_WAIT: begin
`ifdef STORE_ACK_EN
        rsp_load  = 1'b1;
        state_nxt = RESP;
`else
        state_nxt = IDLE;
`endif
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      alu_addr <= '0;
    end else if (pop) begin
      alu_a    <= head.a;
      alu_b    <= head.b;
      alu_op   <= head.op;
      alu_addr <= head.addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_op   <= '0;
      rsp_err  <= 1'b0;
    end else if (rsp_load) begin
      rsp_data <= rsp_data_nxt;
      rsp_op   <= alu_op;
      rsp_err  <= rsp_err_nxt;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an attached ALU/memory stage model and a response scoreboard.
module tb_alu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_a, cmd_b;
  logic [3:0] cmd_addr;
  logic       alu_start;
  logic [1:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_addr;
  logic       alu_done;
  logic [2:0] alu_y, alu_memout;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_data, rsp_op;
  logic       rsp_err, busy;

  typedef struct packed {
    logic [2:0] data;
    logic [2:0] op;
    logic       err;
  } rsp_t;

  rsp_t sb_q[$];
  int   start_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cd;
  logic done_en;
  logic [2:0] smem [16];

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_addr   (cmd_addr),
    .alu_start  (alu_start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_addr   (alu_addr),
    .alu_done   (alu_done),
    .alu_y      (alu_y),
    .alu_memout (alu_memout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: ALU/load finish 3 cycles after start, stores write at the start edge.
  initial for (int i = 0; i < 16; i++) smem[i] = 3'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cd <= 0;
    else if (alu_start && alu_op[2:1] != 2'b11) cd <= 3;
    else if (cd != 0) cd <= cd - 1;
  end

  always @(posedge clk) begin
    if (alu_start && alu_op[2:1] == 2'b11) smem[alu_addr] <= {1'b0, alu_a};
  end

  assign alu_done   = done_en && (cd == 1);
  assign alu_memout = smem[alu_addr];

  always_comb begin
    case (alu_op[1:0])
      2'b00:   alu_y = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_y = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_y = {1'b0, alu_a & alu_b};
      default: alu_y = {1'b0, alu_a | alu_b};
    endcase
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (alu_start) start_q.push_back(cyc);
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got data=%0d op=%0d err=%0d, required no response",
                 rsp_data, rsp_op, rsp_err);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_data", int'(rsp_data), int'(e.data));
        check("rsp_op",   int'(rsp_op),   int'(e.op));
        check("rsp_err",  int'(rsp_err),  int'(e.err));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                      input logic [3:0] addr);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_addr  = addr;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: cmd_ready got 0, required 1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 100);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || busy) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d busy=%0d, required 0 and 0", sb_q.size(), busy);
    end
  endtask

  initial begin
    int lat;
    int base;
    int seen;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_addr  = '0;
    rsp_ready = 1'b1;
    done_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy",      busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_op",    rsp_op, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_regs",  int'({alu_a, alu_b, alu_op, alu_addr}), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Add 3+2: response visible in cycle 6 after acceptance.
    sb_q.push_back('{data: 3'd5, op: 3'b000, err: 1'b0});
    send(3'b000, 2'd3, 2'd2, 4'd0);
    wait_rsp(lat);
    check("add_latency", lat, 6);
    drain(50);

    // Sub 1-2 wraps to 7.
    sb_q.push_back('{data: 3'd7, op: 3'b001, err: 1'b0});
    send(3'b001, 2'd1, 2'd2, 4'd0);
    drain(50);

    // Store 2 to addr 5, then load it back.
    base = start_q.size();
`ifdef STORE_ACK_EN
    sb_q.push_back('{data: 3'd0, op: 3'b110, err: 1'b0});
`endif
    sb_q.push_back('{data: 3'd2, op: 3'b100, err: 1'b0});
    send(3'b110, 2'd2, 2'd0, 4'd5);
    send(3'b100, 2'd0, 2'd0, 4'd5);
    drain(50);
    if (start_q.size() >= base + 2) begin
`ifdef STORE_ACK_EN
      check("store_issue_gap", start_q[base+1] - start_q[base], 4);
`else
      check("store_issue_gap", start_q[base+1] - start_q[base], 3);
`endif
    end else begin
      check("store_issue_count", start_q.size() - base, 2);
    end

    // Fill the FIFO behind a stalled response, then drain in order.
    rsp_ready = 1'b0;
    sb_q.push_back('{data: 3'd3, op: 3'b000, err: 1'b0});
    sb_q.push_back('{data: 3'd7, op: 3'b001, err: 1'b0});
    sb_q.push_back('{data: 3'd2, op: 3'b010, err: 1'b0});
    sb_q.push_back('{data: 3'd3, op: 3'b011, err: 1'b0});
    sb_q.push_back('{data: 3'd6, op: 3'b000, err: 1'b0});
    send(3'b000, 2'd1, 2'd2, 4'd0);
    send(3'b001, 2'd0, 2'd1, 4'd0);
    send(3'b010, 2'd3, 2'd2, 4'd0);
    send(3'b011, 2'd1, 2'd2, 4'd0);
    send(3'b000, 2'd3, 2'd3, 4'd0);
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    repeat (10) @(negedge clk);
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_rsp_data",  rsp_data, 3);
    check("stall_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain(200);

    // Timeout: no completion, error response TIMEOUT cycles after WAIT entry.
    done_en = 1'b0;
    sb_q.push_back('{data: 3'd0, op: 3'b000, err: 1'b1});
    send(3'b000, 2'd1, 2'd1, 4'd0);
    wait_rsp(lat);
    check("timeout_latency", lat, 3 + TIMEOUT);
    drain(50);

    // Reset while in WAIT flushes the command with no response.
    send(3'b000, 2'd1, 2'd1, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy",      busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    done_en = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_stale_rsp", seen, 0);

    // Recovery after reset.
    sb_q.push_back('{data: 3'd4, op: 3'b000, err: 1'b0});
    send(3'b000, 2'd2, 2'd2, 4'd0);
    drain(50);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
